ghost_sprite_renderer: RTL and testbench

Per-pixel renderer for one ghost, producing the 3-bit palette index consumed by the colour mixer's `blinkyColor`/`pinkyColor`/`inkyColor`/`clydeColor` inputs; index 0 means transparent. It sits between the video sync generator, which supplies `hpos`/`vpos`/`vsync`, and the colour mixer. It owns the ghost's visual mode state machine, the frightened countdown and blink timing, and the walk animation. Output is pipelined with a fixed 2-cycle latency.

---
 rtl/pacman_pkg.sv | 34 +++
 rtl/ghost_bitmap_rom.sv | 43 ++++
 rtl/ghost_sprite_renderer.sv | 203 ++++++++++++++++++++
 tb/tb_ghost_sprite_renderer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// rtl/pacman_pkg.sv - shared palette indices, ghost state encoding and sprite body bitmap
package pacman_pkg;

    localparam logic [2:0] BLACK  = 3'd0;
    localparam logic [2:0] YELLOW = 3'd1;
    localparam logic [2:0] RED    = 3'd2;
    localparam logic [2:0] WHITE  = 3'd3;
    localparam logic [2:0] BLUE   = 3'd4;
    localparam logic [2:0] PINK   = 3'd5;
    localparam logic [2:0] CYAN   = 3'd6;
    localparam logic [2:0] ORANGE = 3'd7;

    localparam int SPRITE_SIZE = 16;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_FRIGHT = 2'd1,
        ST_BLINK  = 2'd2,
        ST_EATEN  = 2'd3
    } ghost_state_e;

    // Column 0 is the MSB; rows 14-15 carry the two skirt variants.
    function automatic logic [15:0] body_row(input logic [3:0] row, input logic frame);
        case (row)
            4'd0:    body_row = 16'b0000011111100000;
            4'd1:    body_row = 16'b0001111111111000;
            4'd2:    body_row = 16'b0011111111111100;
            4'd14:   body_row = frame ? 16'b0111111111111110 : 16'b0111101111011110;
            4'd15:   body_row = frame ? 16'b0101101001011010 : 16'b0110001100011000;
            default: body_row = 16'b0111111111111110;
        endcase
    endfunction

endpackage

// File: rtl/ghost_bitmap_rom.sv
// rtl/ghost_bitmap_rom.sv - combinational ghost body, eye-white and pupil masks
module ghost_bitmap_rom
    import pacman_pkg::*;
(
    input  logic [3:0] row,
    input  logic [3:0] col,
    input  logic       frame,
    input  logic [1:0] dir,
    output logic       body,
    output logic       eye_white,
    output logic       pupil
);

    logic [15:0] body_bits;
    logic        in_left;
    logic        in_right;
    logic        in_eye;
    logic [1:0]  ex;
    logic [1:0]  ey;
    logic [1:0]  px;
    logic [1:0]  py;

    // Eyes are 4x4 blocks at columns 2-5 and 8-11, rows 4-7.
    always_comb begin
        body_bits = body_row(row, frame);
        body      = body_bits[4'd15 - col];
        in_left   = (col >= 4'd2) && (col <= 4'd5);
        in_right  = (col >= 4'd8) && (col <= 4'd11);
        in_eye    = (row >= 4'd4) && (row <= 4'd7) && (in_left || in_right);
        ex        = in_right ? col[1:0] : col[1:0] - 2'd2;
        ey        = row[1:0];
        case (dir)
            2'd0:    begin px = 2'd2; py = 2'd1; end
            2'd1:    begin px = 2'd0; py = 2'd1; end
            2'd2:    begin px = 2'd1; py = 2'd0; end
            default: begin px = 2'd1; py = 2'd2; end
        endcase
        eye_white = in_eye;
        pupil     = in_eye && (ex >= px) && ((ex - px) <= 2'd1)
                           && (ey >= py) && ((ey - py) <= 2'd1);
    end

endmodule

// File: rtl/ghost_sprite_renderer.sv
// rtl/ghost_sprite_renderer.sv - ghost mode FSM and 2-stage pixel renderer; GHOST_BLINK_EN enables the BLINK state
module ghost_sprite_renderer
    import pacman_pkg::*;
#(
    parameter logic [2:0] BODY_COLOR    = 3'd2,
    parameter int         ANIM_PERIOD   = 8,
    parameter int         FRIGHT_FRAMES = 360,
    parameter int         BLINK_START   = 120,
    parameter int         BLINK_HALF    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    input  logic       vsync,
    input  logic [8:0] ghost_x,
    input  logic [8:0] ghost_y,
    input  logic [1:0] dir,
    input  logic       fright_start,
    input  logic       eaten,
    input  logic       revive,
    output logic [2:0] color,
    output logic       frightened
);

    localparam int ACW = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;

    ghost_state_e   state_q, state_d;
    logic [8:0]     timer_q, timer_d;
    logic [ACW-1:0] anim_cnt_q, anim_cnt_d;
    logic           anim_frame_q, anim_frame_d;
    logic           blink_phase_q, blink_phase_d;
    logic           frightened_q, frightened_d;
    logic [3:0]     rx_q, rx_d;
    logic [3:0]     ry_q, ry_d;
    logic           inside_q, inside_d;
    logic           frame_q, frame_d;
    logic [2:0]     color_q, color_d;
    logic [8:0]     rx_full;
    logic [8:0]     ry_full;
    logic           body;
    logic           eye_white;
    logic           pupil;

`ifdef GHOST_BLINK_EN
    localparam int BCW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (vsync && timer_q != 9'd0 && (state_q == ST_FRIGHT || state_q == ST_BLINK))
            timer_d = timer_q - 9'd1;
        case (state_q)
            ST_NORMAL: begin
                if (fright_start) begin
                    state_d = ST_FRIGHT;
                    timer_d = 9'(FRIGHT_FRAMES);
                end
            end
            ST_FRIGHT: begin
                if (eaten)
                    state_d = ST_EATEN;
                else if (fright_start)
                    timer_d = 9'(FRIGHT_FRAMES);
`ifdef GHOST_BLINK_EN
                else if (timer_q <= 9'(BLINK_START))
                    state_d = ST_BLINK;
`else
                else if (timer_q == 9'd0)
                    state_d = ST_NORMAL;
`endif
            end
            ST_BLINK: begin
                if (eaten)
                    state_d = ST_EATEN;
                else if (fright_start) begin
                    state_d = ST_FRIGHT;
                    timer_d = 9'(FRIGHT_FRAMES);
                end else if (timer_q == 9'd0)
                    state_d = ST_NORMAL;
            end
            default: begin
                if (revive)
                    state_d = ST_NORMAL;
            end
        endcase
        frightened_d = (state_d == ST_FRIGHT) || (state_d == ST_BLINK);
    end

    always_comb begin
        anim_cnt_d   = anim_cnt_q;
        anim_frame_d = anim_frame_q;
        if (vsync) begin
            if (anim_cnt_q == ACW'(ANIM_PERIOD - 1)) begin
                anim_cnt_d   = '0;
                anim_frame_d = ~anim_frame_q;
            end else begin
                anim_cnt_d = anim_cnt_q + 1'b1;
            end
        end
    end

`ifdef GHOST_BLINK_EN
    // Phase restarts at 0 whenever BLINK is entered.
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (state_q != ST_BLINK && state_d == ST_BLINK) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (state_q == ST_BLINK && vsync) begin
            if (blink_cnt_q == BCW'(BLINK_HALF - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end
`else
    assign blink_phase_d = 1'b0;
`endif

    always_comb begin
        rx_full  = hpos - ghost_x;
        ry_full  = vpos - ghost_y;
        inside_d = (rx_full < 9'(SPRITE_SIZE)) && (ry_full < 9'(SPRITE_SIZE));
        rx_d     = rx_full[3:0];
        ry_d     = ry_full[3:0];
        frame_d  = anim_frame_q;
    end

    ghost_bitmap_rom u_rom (
        .row       (ry_q),
        .col       (rx_q),
        .frame     (frame_q),
        .dir       (dir),
        .body      (body),
        .eye_white (eye_white),
        .pupil     (pupil)
    );

    // Priority pupil > eye white > body; frightened faces merge white and pupil.
    always_comb begin
        color_d = BLACK;
        if (inside_q) begin
            case (state_q)
                ST_NORMAL: color_d = pupil ? BLUE : eye_white ? WHITE : body ? BODY_COLOR : BLACK;
                ST_FRIGHT: color_d = (pupil || eye_white) ? PINK : body ? BLUE : BLACK;
`ifdef GHOST_BLINK_EN
                ST_BLINK: begin
                    if (blink_phase_q)
                        color_d = (pupil || eye_white) ? RED : body ? WHITE : BLACK;
                    else
                        color_d = (pupil || eye_white) ? PINK : body ? BLUE : BLACK;
                end
`endif
                ST_EATEN:  color_d = pupil ? BLUE : eye_white ? WHITE : BLACK;
                default:   color_d = BLACK;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_NORMAL;
            timer_q       <= 9'd0;
            anim_cnt_q    <= '0;
            anim_frame_q  <= 1'b0;
            blink_phase_q <= 1'b0;
            frightened_q  <= 1'b0;
            rx_q          <= 4'd0;
            ry_q          <= 4'd0;
            inside_q      <= 1'b0;
            frame_q       <= 1'b0;
            color_q       <= 3'd0;
`ifdef GHOST_BLINK_EN
            blink_cnt_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            anim_cnt_q    <= anim_cnt_d;
            anim_frame_q  <= anim_frame_d;
            blink_phase_q <= blink_phase_d;
            frightened_q  <= frightened_d;
            rx_q          <= rx_d;
            ry_q          <= ry_d;
            inside_q      <= inside_d;
            frame_q       <= frame_d;
            color_q       <= color_d;
`ifdef GHOST_BLINK_EN
            blink_cnt_q   <= blink_cnt_d;
`endif
        end
    end

    assign color      = color_q;
    assign frightened = frightened_q;

endmodule

// File: tb/tb_ghost_sprite_renderer.sv
// tb/tb_ghost_sprite_renderer.sv - directed self-checking bench for ghost_sprite_renderer
module tb_ghost_sprite_renderer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] hpos = 9'd0;
    logic [8:0] vpos = 9'd0;
    logic       vsync = 1'b0;
    logic [8:0] ghost_x = 9'd100;
    logic [8:0] ghost_y = 9'd50;
    logic [1:0] dir = 2'd0;
    logic       fright_start = 1'b0;
    logic       eaten = 1'b0;
    logic       revive = 1'b0;
    logic [2:0] color;
    logic       frightened;

    int checks = 0;
    int errors = 0;

`ifdef GHOST_BLINK_EN
    localparam bit BLINK_BUILD = 1'b1;
`else
    localparam bit BLINK_BUILD = 1'b0;
`endif

    ghost_sprite_renderer #(.BODY_COLOR(3'd2)) dut (
        .clk          (clk),
        .reset        (reset),
        .hpos         (hpos),
        .vpos         (vpos),
        .vsync        (vsync),
        .ghost_x      (ghost_x),
        .ghost_y      (ghost_y),
        .dir          (dir),
        .fright_start (fright_start),
        .eaten        (eaten),
        .revive       (revive),
        .color        (color),
        .frightened   (frightened)
    );

    always #5 clk = ~clk;

    task automatic probe(input logic [8:0] h, input logic [8:0] v, output logic [2:0] c);
        @(negedge clk);
        hpos = h;
        vpos = v;
        @(negedge clk);
        @(negedge clk);
        c = color;
    endtask

    task automatic pulse_vsync(input int n);
        repeat (n) begin
            @(negedge clk);
            vsync = 1'b1;
            @(negedge clk);
            vsync = 1'b0;
        end
    endtask

    task automatic pulse(input int which);
        @(negedge clk);
        if (which == 0) fright_start = 1'b1;
        if (which == 1) eaten = 1'b1;
        if (which == 2) revive = 1'b1;
        @(negedge clk);
        fright_start = 1'b0;
        eaten = 1'b0;
        revive = 1'b0;
    endtask

    task automatic test_reset();
        logic [2:0] c;
        reset = 1'b1;
        fright_start = 1'b1;
        hpos = 9'd101;
        vpos = 9'd55;
        repeat (3) @(negedge clk);
        checks++;
        if (color !== 3'd0) begin errors++; $display("FAIL reset_color got %0d want 0", color); end
        checks++;
        if (frightened !== 1'b0) begin errors++; $display("FAIL reset_frightened got %0d want 0", frightened); end
        reset = 1'b0;
        fright_start = 1'b0;
        @(negedge clk);
        checks++;
        if (frightened !== 1'b0) begin errors++; $display("FAIL reset_pulse_dropped got %0d want 0", frightened); end
        probe(9'd101, 9'd55, c);
        checks++;
        if (c !== 3'd2) begin errors++; $display("FAIL reset_normal_body got %0d want 2", c); end
    endtask

    task automatic test_normal_row();
        logic [2:0] c;
        logic [2:0] exp_row [16];
        logic [2:0] e;
        exp_row = '{3'd0, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd2, 3'd2,
                    3'd3, 3'd3, 3'd4, 3'd4, 3'd2, 3'd2, 3'd2, 3'd0};
        for (int i = 0; i < 18; i++) begin
            e = (i == 0 || i == 17) ? 3'd0 : exp_row[i-1];
            probe(9'(99 + i), 9'd55, c);
            checks++;
            if (c !== e) begin errors++; $display("FAIL normal_row hpos=%0d got %0d want %0d", 99 + i, c, e); end
        end
    endtask

    task automatic test_skirt();
        logic [2:0] c;
        logic [2:0] exp_row [16];
        exp_row = '{3'd0, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd2, 3'd2,
                    3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0};
        for (int i = 0; i < 16; i++) begin
            probe(9'(100 + i), 9'd65, c);
            checks++;
            if (c !== exp_row[i]) begin errors++; $display("FAIL skirt_row col=%0d got %0d want %0d", i, c, exp_row[i]); end
        end
    endtask

    task automatic test_wrap();
        logic [2:0] c;
        logic [8:0] hs [10];
        logic [2:0] es [10];
        hs = '{9'd507, 9'd508, 9'd509, 9'd511, 9'd0, 9'd2, 9'd6, 9'd10, 9'd11, 9'd12};
        es = '{3'd0, 3'd0, 3'd2, 3'd3, 3'd4, 3'd2, 3'd4, 3'd2, 3'd0, 3'd0};
        ghost_x = 9'd508;
        for (int i = 0; i < 10; i++) begin
            probe(hs[i], 9'd55, c);
            checks++;
            if (c !== es[i]) begin errors++; $display("FAIL wrap hpos=%0d got %0d want %0d", hs[i], c, es[i]); end
        end
        ghost_x = 9'd100;
    endtask

    task automatic test_dir();
        logic [2:0] c;
        logic [2:0] exp_row [16];
        exp_row = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd2, 3'd2,
                    3'd3, 3'd4, 3'd4, 3'd3, 3'd2, 3'd2, 3'd2, 3'd0};
        dir = 2'd2;
        for (int i = 0; i < 16; i++) begin
            probe(9'(100 + i), 9'd54, c);
            checks++;
            if (c !== exp_row[i]) begin errors++; $display("FAIL dir_up_row col=%0d got %0d want %0d", i, c, exp_row[i]); end
        end
        probe(9'd104, 9'd56, c);
        checks++;
        if (c !== 3'd3) begin errors++; $display("FAIL dir_up_white got %0d want 3", c); end
        dir = 2'd3;
        probe(9'd103, 9'd57, c);
        checks++;
        if (c !== 3'd4) begin errors++; $display("FAIL dir_down_pupil got %0d want 4", c); end
        dir = 2'd1;
        probe(9'd102, 9'd55, c);
        checks++;
        if (c !== 3'd4) begin errors++; $display("FAIL dir_left_pupil got %0d want 4", c); end
        probe(9'd104, 9'd55, c);
        checks++;
        if (c !== 3'd3) begin errors++; $display("FAIL dir_left_white got %0d want 3", c); end
        dir = 2'd0;
    endtask

    task automatic test_fright();
        logic [2:0] c;
        logic [2:0] e;
        pulse(0);
        checks++;
        if (frightened !== 1'b1) begin errors++; $display("FAIL fright_flag got %0d want 1", frightened); end
        probe(9'd101, 9'd55, c);
        checks++;
        if (c !== 3'd4) begin errors++; $display("FAIL fright_body got %0d want 4", c); end
        probe(9'd102, 9'd55, c);
        checks++;
        if (c !== 3'd5) begin errors++; $display("FAIL fright_face got %0d want 5", c); end
        pulse_vsync(244);
        probe(9'd101, 9'd55, c);
        checks++;
        if (c !== 3'd4) begin errors++; $display("FAIL blink_ph0_body got %0d want 4", c); end
        pulse_vsync(8);
        e = BLINK_BUILD ? 3'd3 : 3'd4;
        probe(9'd101, 9'd55, c);
        checks++;
        if (c !== e) begin errors++; $display("FAIL blink_ph1_body got %0d want %0d", c, e); end
        e = BLINK_BUILD ? 3'd2 : 3'd5;
        probe(9'd102, 9'd55, c);
        checks++;
        if (c !== e) begin errors++; $display("FAIL blink_ph1_face got %0d want %0d", c, e); end
        pulse_vsync(8);
        probe(9'd101, 9'd55, c);
        checks++;
        if (c !== 3'd4) begin errors++; $display("FAIL blink_ph0_again got %0d want 4", c); end
        pulse_vsync(99);
        checks++;
        if (frightened !== 1'b1) begin errors++; $display("FAIL fright_at_359 got %0d want 1", frightened); end
        pulse_vsync(1);
        @(negedge clk);
        checks++;
        if (frightened !== 1'b0) begin errors++; $display("FAIL fright_end_flag got %0d want 0", frightened); end
        probe(9'd101, 9'd55, c);
        checks++;
        if (c !== 3'd2) begin errors++; $display("FAIL fright_end_body got %0d want 2", c); end
    endtask

    task automatic test_refright_and_eaten();
        logic [2:0] c;
        logic [2:0] e;
        logic [2:0] exp_row [16];
        exp_row = '{3'd0, 3'd0, 3'd3, 3'd3, 3'd4, 3'd4, 3'd0, 3'd0,
                    3'd3, 3'd3, 3'd4, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0};
        pulse(0);
        pulse_vsync(160);
        pulse(0);
        checks++;
        if (frightened !== 1'b1) begin errors++; $display("FAIL refright_flag got %0d want 1", frightened); end
        pulse_vsync(300);
        e = BLINK_BUILD ? 3'd3 : 3'd4;
        probe(9'd101, 9'd55, c);
        checks++;
        if (c !== e) begin errors++; $display("FAIL refright_300 got %0d want %0d", c, e); end
        pulse_vsync(59);
        checks++;
        if (frightened !== 1'b1) begin errors++; $display("FAIL refright_359 got %0d want 1", frightened); end
        @(negedge clk);
        eaten = 1'b1;
        fright_start = 1'b1;
        @(negedge clk);
        eaten = 1'b0;
        fright_start = 1'b0;
        checks++;
        if (frightened !== 1'b0) begin errors++; $display("FAIL eaten_wins_flag got %0d want 0", frightened); end
        for (int i = 0; i < 16; i++) begin
            probe(9'(100 + i), 9'd55, c);
            checks++;
            if (c !== exp_row[i]) begin errors++; $display("FAIL eaten_row col=%0d got %0d want %0d", i, c, exp_row[i]); end
        end
    endtask

    task automatic test_eaten_ignores_fright();
        logic [2:0] c;
        pulse(0);
        checks++;
        if (frightened !== 1'b0) begin errors++; $display("FAIL eaten_ignore_flag got %0d want 0", frightened); end
        probe(9'd101, 9'd55, c);
        checks++;
        if (c !== 3'd0) begin errors++; $display("FAIL eaten_ignore_body got %0d want 0", c); end
    endtask

    task automatic test_revive();
        logic [2:0] c;
        pulse(2);
        probe(9'd101, 9'd55, c);
        checks++;
        if (c !== 3'd2) begin errors++; $display("FAIL revive_body got %0d want 2", c); end
        pulse(2);
        pulse(1);
        probe(9'd101, 9'd55, c);
        checks++;
        if (c !== 3'd2) begin errors++; $display("FAIL ignored_pulses_body got %0d want 2", c); end
        checks++;
        if (frightened !== 1'b0) begin errors++; $display("FAIL ignored_pulses_flag got %0d want 0", frightened); end
    endtask

    task automatic test_reset_mid_eaten();
        logic [2:0] c;
        pulse(0);
        pulse(1);
        probe(9'd101, 9'd55, c);
        checks++;
        if (c !== 3'd0) begin errors++; $display("FAIL pre_reset_eaten got %0d want 0", c); end
        @(negedge clk);
        reset = 1'b1;
        fright_start = 1'b1;
        @(negedge clk);
        checks++;
        if (color !== 3'd0) begin errors++; $display("FAIL mid_reset_color got %0d want 0", color); end
        checks++;
        if (frightened !== 1'b0) begin errors++; $display("FAIL mid_reset_flag got %0d want 0", frightened); end
        reset = 1'b0;
        fright_start = 1'b0;
        probe(9'd101, 9'd55, c);
        checks++;
        if (c !== 3'd2) begin errors++; $display("FAIL post_reset_body got %0d want 2", c); end
        checks++;
        if (frightened !== 1'b0) begin errors++; $display("FAIL post_reset_flag got %0d want 0", frightened); end
    endtask

    initial begin
        test_reset();
        test_normal_row();
        test_skirt();
        test_wrap();
        test_dir();
        test_fright();
        test_refright_and_eaten();
        test_eaten_ignores_fright();
        test_revive();
        test_reset_mid_eaten();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
